// File: rtl/qrs_detect_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | qrs_detect_pkg : shared types, widths and shift constants          |
// | Revision       : 1.0                                               |
// +--------------------------------------------------------------------+
package qrs_detect_pkg;

  localparam int c_sample_w        = 16;
  localparam int c_spki_init_shift = 1;
  localparam int c_npki_init_shift = 3;
  localparam int c_thr_shift       = 2;
  localparam int c_level_shift     = 3;

  typedef enum logic [0:0] {
    LEARN  = 1'b0,
    DETECT = 1'b1
  } state_t;

  // Running level estimate: level + floor((peak - level) / 8), no overflow for 16-bit inputs
  function automatic logic [c_sample_w-1:0] level_update(
    input logic [c_sample_w-1:0] level,
    input logic [c_sample_w-1:0] peak
  );
    logic signed [c_sample_w:0] d;
    logic signed [c_sample_w:0] s;
    d = $signed({1'b0, peak}) - $signed({1'b0, level});
    s = $signed({1'b0, level}) + (d >>> c_level_shift);
    return s[c_sample_w-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/qrs_detect_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | qrs_detect_if : sample stream in, detection results out            |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
interface qrs_detect_if;
  import qrs_detect_pkg::*;

  logic                         sample_valid;
  logic signed [c_sample_w-1:0] sample_in;
  logic                         qrs_pulse;
  logic        [c_sample_w-1:0] peak_value;
  logic        [c_sample_w-1:0] rr_interval;
  logic                         rr_valid;
  logic        [c_sample_w-1:0] threshold;
  logic                         learning;

  modport master (
    output sample_valid, sample_in,
    input  qrs_pulse, peak_value, rr_interval, rr_valid, threshold, learning
  );

  modport slave (
    input  sample_valid, sample_in,
    output qrs_pulse, peak_value, rr_interval, rr_valid, threshold, learning
  );

endinterface
`default_nettype wire

// File: rtl/qrs_peak_find.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | qrs_peak_find : two-sample history and local-maximum candidate     |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
module qrs_peak_find
  import qrs_detect_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [c_sample_w-1:0] i_x,
  output logic                  o_cand,
  output logic [c_sample_w-1:0] o_cand_val
);

  logic [c_sample_w-1:0] r_x1;
  logic [c_sample_w-1:0] r_x2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x1 <= '0;
      r_x2 <= '0;
    end else if (i_valid) begin
      r_x2 <= r_x1;
      r_x1 <= i_x;
    end
  end

  // Rising edge into x1 and no further rise at x: x1 is a local maximum
  assign o_cand     = (r_x1 > r_x2) && (r_x1 >= i_x);
  assign o_cand_val = r_x1;

endmodule
`default_nettype wire

// File: rtl/qrs_detect.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | qrs_detect : adaptive-threshold QRS detector with learning phase   |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
module qrs_detect
  import qrs_detect_pkg::*;
#(
  parameter int LEARN_LEN = 400,
  parameter int REFRACT   = 40
) (
  input  logic         clk,
  input  logic         reset,
  qrs_detect_if.slave  bus
);

  localparam logic [15:0] c_learn_last = 16'(LEARN_LEN - 1);
  localparam logic [7:0]  c_refract    = 8'(REFRACT);

  state_t                r_state;
  state_t                w_state_next;
  logic                  w_learning;

  logic [c_sample_w-1:0] w_x;
  logic                  w_cand;
  logic [c_sample_w-1:0] w_cand_val;
  logic [c_sample_w-1:0] w_max_next;
  logic                  w_learn_done;
  logic                  w_eval;
  logic                  w_qrs;
  logic                  w_noise;
  logic signed [c_sample_w:0] w_thr_wide;
  logic [c_sample_w-1:0] w_threshold;

  logic [c_sample_w-1:0] r_spki;
  logic [c_sample_w-1:0] r_npki;
  logic [c_sample_w-1:0] r_max;
  logic [15:0]           r_learn_cnt;
  logic [7:0]            r_refract;
  logic [15:0]           r_rr_cnt;
  logic                  r_seen_qrs;
  logic                  r_qrs_pulse;
  logic                  r_rr_valid;
  logic [c_sample_w-1:0] r_peak_value;
  logic [c_sample_w-1:0] r_rr_interval;

  assign w_x = bus.sample_in[c_sample_w-1] ? '0 : bus.sample_in;

  qrs_peak_find u_peak_find (
    .clk        (clk),
    .rst        (reset),
    .i_valid    (bus.sample_valid),
    .i_x        (w_x),
    .o_cand     (w_cand),
    .o_cand_val (w_cand_val)
  );

  assign w_max_next   = (w_x > r_max) ? w_x : r_max;
  assign w_learn_done = (r_learn_cnt == c_learn_last);

  assign w_thr_wide  = $signed({1'b0, r_npki})
                     + (($signed({1'b0, r_spki}) - $signed({1'b0, r_npki})) >>> c_thr_shift);
  assign w_threshold = w_thr_wide[c_sample_w] ? '0 : w_thr_wide[c_sample_w-1:0];

  assign w_eval  = bus.sample_valid && (r_state == DETECT) && w_cand && (r_refract == 8'd0);
  assign w_qrs   = w_eval && (w_cand_val > w_threshold);
  assign w_noise = w_eval && !(w_cand_val > w_threshold);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= LEARN;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      LEARN:   if (bus.sample_valid && w_learn_done) w_state_next = DETECT;
      DETECT:  w_state_next = DETECT;
      default: w_state_next = LEARN;
    endcase
  end

  always_comb begin
    w_learning = (r_state == LEARN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_spki        <= '0;
      r_npki        <= '0;
      r_max         <= '0;
      r_learn_cnt   <= '0;
      r_refract     <= '0;
      r_rr_cnt      <= '0;
      r_seen_qrs    <= 1'b0;
      r_qrs_pulse   <= 1'b0;
      r_rr_valid    <= 1'b0;
      r_peak_value  <= '0;
      r_rr_interval <= '0;
    end else begin
      r_qrs_pulse <= 1'b0;
      r_rr_valid  <= 1'b0;
      if (bus.sample_valid) begin
        if (r_state == LEARN) begin
          r_max       <= w_max_next;
          r_learn_cnt <= r_learn_cnt + 16'd1;
          if (w_learn_done) begin
            r_spki <= w_max_next >> c_spki_init_shift;
            r_npki <= w_max_next >> c_npki_init_shift;
          end
        end else if (w_qrs) begin
          r_spki        <= level_update(r_spki, w_cand_val);
          r_refract     <= c_refract;
          r_rr_interval <= r_rr_cnt;
          r_rr_cnt      <= 16'd1;
          r_seen_qrs    <= 1'b1;
          r_qrs_pulse   <= 1'b1;
          r_rr_valid    <= r_seen_qrs;
          r_peak_value  <= w_cand_val;
        end else begin
          if (w_noise) r_npki <= level_update(r_npki, w_cand_val);
          if (r_refract != 8'd0) r_refract <= r_refract - 8'd1;
          if (r_rr_cnt != 16'hFFFF) r_rr_cnt <= r_rr_cnt + 16'd1;
        end
      end
    end
  end

  assign bus.qrs_pulse   = r_qrs_pulse;
  assign bus.rr_valid    = r_rr_valid;
  assign bus.peak_value  = r_peak_value;
  assign bus.rr_interval = r_rr_interval;
  assign bus.threshold   = w_threshold;
  assign bus.learning    = w_learning;

endmodule
`default_nettype wire

// File: tb/tb_qrs_detect.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_qrs_detect : scoreboard bench for qrs_detect (LEARN_LEN=8, R=4) |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
module tb_qrs_detect;
  import qrs_detect_pkg::*;

  typedef struct packed {
    logic [31:0] cyc;
    logic [15:0] peak;
    logic        rv;
    logic [15:0] rr;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  ev_t         exp_q[$];
  ev_t         obs_q[$];
  int          std_pat[8] = '{0, 0, 800, 0, 0, 0, 0, 0};
  int          new_pat[8] = '{0, 0, 0, 0, 600, 0, 500, 0};

  qrs_detect_if bus();

  qrs_detect #(.LEARN_LEN(8), .REFRACT(4)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every strobe cycle becomes one observed event; rr_interval only matters with rr_valid
  always @(negedge clk)
    if (bus.qrs_pulse === 1'b1)
      obs_q.push_back({cyc, bus.peak_value, bus.rr_valid, bus.rr_valid ? bus.rr_interval : 16'd0});

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input int v, input bit valid);
    @(negedge clk);
    bus.sample_valid = valid;
    bus.sample_in    = 16'(v);
    @(posedge clk);
    #1;
    bus.sample_valid = 1'b0;
  endtask

  task automatic expect_qrs(input int peak, input bit rv, input int rr);
    exp_q.push_back({32'(cyc), 16'(peak), rv, 16'(rr)});
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic learn(input int pat[8]);
    foreach (pat[i]) drive(pat[i], 1'b1);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (bus.qrs_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %0b want 0", bus.qrs_pulse); end
    checks++; if (bus.rr_valid !== 1'b0) begin errors++; $display("FAIL reset_rr_valid: got %0b want 0", bus.rr_valid); end
    checks++; if (bus.peak_value !== 16'd0) begin errors++; $display("FAIL reset_peak: got %0d want 0", bus.peak_value); end
    checks++; if (bus.rr_interval !== 16'd0) begin errors++; $display("FAIL reset_rr: got %0d want 0", bus.rr_interval); end
    checks++; if (bus.threshold !== 16'd0) begin errors++; $display("FAIL reset_thr: got %0d want 0", bus.threshold); end
    checks++; if (bus.learning !== 1'b1) begin errors++; $display("FAIL reset_learning: got %0b want 1", bus.learning); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_learning();
    for (int i = 0; i < 8; i++) begin
      drive(std_pat[i], 1'b1);
      checks++;
      if (bus.learning !== (i < 7)) begin
        errors++; $display("FAIL learning_s%0d: got %0b want %0b", i, bus.learning, (i < 7));
      end
    end
    checks++; if (bus.threshold !== 16'd175) begin errors++; $display("FAIL learn_thr: got %0d want 175", bus.threshold); end
    drive(0, 1'b0);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL learn_no_pulse: got %0d pulses want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_qrs();
    ev_t e, o;
    drive(0, 1'b1); drive(1000, 1'b1); drive(0, 1'b1);
    expect_qrs(1000, 1'b0, 0);
    drive(0, 1'b0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL qrs_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL qrs_event: got cyc=%0d peak=%0d rv=%0b rr=%0d want cyc=%0d peak=%0d rv=%0b rr=%0d", o.cyc, o.peak, o.rv, o.rr, e.cyc, e.peak, e.rv, e.rr); end
    end
    exp_q.delete(); obs_q.delete();
    checks++; if (bus.threshold !== 16'd193) begin errors++; $display("FAIL qrs_thr: got %0d want 193", bus.threshold); end
  endtask

  task automatic test_noise();
    apply_reset();
    learn(std_pat);
    drive(0, 1'b1); drive(50, 1'b1); drive(0, 1'b1);
    checks++; if (bus.threshold !== 16'd169) begin errors++; $display("FAIL noise_thr: got %0d want 169", bus.threshold); end
    drive(0, 1'b0);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL noise_no_pulse: got %0d pulses want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_refractory_rr();
    ev_t e, o;
    apply_reset();
    learn(std_pat);
    drive(0, 1'b1); drive(1000, 1'b1); drive(0, 1'b1);
    expect_qrs(1000, 1'b0, 0);
    drive(0, 1'b1); drive(1000, 1'b1); drive(0, 1'b1);
    drive(0, 1'b1); drive(1000, 1'b1); drive(0, 1'b1);
    expect_qrs(1000, 1'b1, 6);
    repeat (8) drive(0, 1'b1);
    drive(1000, 1'b1); drive(0, 1'b1);
    expect_qrs(1000, 1'b1, 10);
    drive(0, 1'b0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rr_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL rr_event: got cyc=%0d peak=%0d rv=%0b rr=%0d want cyc=%0d peak=%0d rv=%0b rr=%0d", o.cyc, o.peak, o.rv, o.rr, e.cyc, e.peak, e.rv, e.rr); end
    end
    exp_q.delete(); obs_q.delete();
    checks++; if (bus.threshold !== 16'd224) begin errors++; $display("FAIL rr_thr: got %0d want 224", bus.threshold); end
  endtask

  task automatic test_negative_gaps_reset();
    ev_t e, o;
    apply_reset();
    learn(std_pat);
    drive(-500, 1'b1); drive(1000, 1'b1);
    repeat (3) drive(0, 1'b0);
    drive(-500, 1'b1);
    expect_qrs(1000, 1'b0, 0);
    repeat (5) begin drive(0, 1'b0); drive(-500, 1'b1); end
    drive(1000, 1'b1); drive(0, 1'b0); drive(-500, 1'b1);
    expect_qrs(1000, 1'b1, 7);
    drive(0, 1'b0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL neg_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL neg_event: got cyc=%0d peak=%0d rv=%0b rr=%0d want cyc=%0d peak=%0d rv=%0b rr=%0d", o.cyc, o.peak, o.rv, o.rr, e.cyc, e.peak, e.rv, e.rr); end
    end
    exp_q.delete(); obs_q.delete();
    checks++; if (bus.threshold !== 16'd210) begin errors++; $display("FAIL neg_thr: got %0d want 210", bus.threshold); end
    // Reset lands between clock edges so only an asynchronous clear can pass these
    @(posedge clk); #2; rst = 1'b1; #1;
    checks++; if (bus.peak_value !== 16'd0) begin errors++; $display("FAIL async_peak: got %0d want 0", bus.peak_value); end
    checks++; if (bus.rr_interval !== 16'd0) begin errors++; $display("FAIL async_rr: got %0d want 0", bus.rr_interval); end
    checks++; if (bus.threshold !== 16'd0) begin errors++; $display("FAIL async_thr: got %0d want 0", bus.threshold); end
    checks++; if (bus.learning !== 1'b1) begin errors++; $display("FAIL async_learning: got %0b want 1", bus.learning); end
    checks++; if (bus.qrs_pulse !== 1'b0 || bus.rr_valid !== 1'b0) begin errors++; $display("FAIL async_strobes: got %0b%0b want 00", bus.qrs_pulse, bus.rr_valid); end
    @(negedge clk); rst = 1'b0;
    obs_q.delete();
    for (int i = 0; i < 8; i++) begin
      drive(new_pat[i], 1'b1);
      checks++;
      if (bus.learning !== (i < 7)) begin
        errors++; $display("FAIL relearn_s%0d: got %0b want %0b", i, bus.learning, (i < 7));
      end
    end
    checks++; if (bus.threshold !== 16'd131) begin errors++; $display("FAIL relearn_thr: got %0d want 131", bus.threshold); end
    drive(0, 1'b0);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL relearn_no_pulse: got %0d pulses want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  initial begin
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    test_reset();
    test_learning();
    test_qrs();
    test_noise();
    test_refractory_rr();
    test_negative_gaps_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/qrs_detect.md
QRS_DETECT -- requirements
Module: qrs_detect

Interface
REQ-001 Parameter LEARN_LEN, default 400, number of valid samples in the learning phase (2 s at 200 Hz); legal range 1..65535.
REQ-002 Parameter REFRACT, default 40, refractory length in valid samples (200 ms at 200 Hz); legal range 1..255.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sample_valid  input  1  qualifies sample_in for one clk cycle; gaps are allowed.
REQ-006 sample_in  input  16  signed moving-window-integrator output from the downsampled filter chain.
REQ-007 qrs_pulse  output  1  one-cycle strobe marking a detected QRS complex.
REQ-008 peak_value  output  16  unsigned amplitude of the last detected QRS peak.
REQ-009 rr_interval  output  16  valid-sample count between the last two QRS detections.
REQ-010 rr_valid  output  1  one-cycle strobe, coincident with qrs_pulse, when rr_interval has been updated.
REQ-011 threshold  output  16  current detection threshold, unsigned.
REQ-012 learning  output  1  high while the block is in state LEARN.

Function
REQ-013 Negative sample_in values are clamped to 0; all subsequent arithmetic is on 16-bit unsigned values x.
REQ-014 Only cycles with sample_valid=1 change internal state; with sample_valid=0 every register holds its value.
REQ-015 History registers x1 (previous sample) and x2 (sample before x1) are updated on every valid sample, in both states.
REQ-016 A peak candidate exists at the current sample x when x1 > x2 and x1 >= x; the candidate value is x1.
REQ-017 Two states: LEARN and DETECT. Reset enters LEARN.
REQ-018 LEARN: track M = maximum clamped sample; after LEARN_LEN valid samples, go to DETECT and set SPKI=M>>1 and NPKI=M>>3.
REQ-019 No qrs_pulse or rr_valid is produced in LEARN, and SPKI/NPKI do not change in LEARN.
REQ-020 threshold = NPKI + ((SPKI-NPKI)>>>2), computed with a 17-bit signed intermediate; a result below 0 gives 0.
REQ-021 DETECT: when a candidate exists, the refractory counter is 0, and the candidate is strictly greater than threshold, a QRS is detected. Then SPKI += (peak-SPKI)>>>3, using arithmetic shift with floor rounding.
REQ-022 DETECT: when a candidate exists, the refractory counter is 0, and the candidate is <= threshold, it is a noise peak. Then NPKI += (peak-NPKI)>>>3.
REQ-023 Candidates arriving while the refractory counter is nonzero are ignored and do not update SPKI or NPKI.
REQ-024 On a QRS decision, the refractory counter loads REFRACT. Otherwise it decrements by 1 per valid sample, down to 0.
REQ-025 RR counter: each valid sample in DETECT increments it, saturating at 16'hFFFF. On a QRS decision, rr_interval <= counter and the counter is set to 1.
REQ-026 rr_valid is asserted only for the second and later QRS decisions after entering DETECT.
REQ-027 Latency: qrs_pulse, rr_valid and peak_value update in the clk cycle after the deciding sample_valid cycle. The strobes are high for exactly one cycle.
REQ-028 The threshold output reflects updated SPKI/NPKI one clk cycle after the deciding sample.
REQ-029 If the sample that completes LEARN also shows a candidate, that candidate is ignored.

Reset
REQ-030 Reset forces state LEARN and sets learning=1.
REQ-031 Reset clears the following to 0: qrs_pulse, rr_valid, peak_value, rr_interval, threshold, SPKI, NPKI, M, x1, x2, the refractory counter, the RR counter, the learn counter, and the first-QRS flag.
REQ-032 Reset asserted mid-operation discards all learned levels; a full new learning phase follows reset release.

Structure
REQ-033 A shared package holds the state enum (LEARN, DETECT), the 16-bit sample width constant, and the shift constants 1, 3, 2, 3 used in REQ-018 and REQ-020..REQ-022.
REQ-034 One sub-module, qrs_peak_find, contains x1/x2 and the candidate logic of REQ-015..REQ-016. The FSM, level tracking and counters stay in qrs_detect.

Verification
All scenarios use LEARN_LEN=8 and REFRACT=4.
REQ-035 Learning phase: drive 8 samples 0,0,800,0,0,0,0,0.
- Learning falls after the 8th sample.
- SPKI=400, NPKI=100, threshold=175.
- No qrs_pulse during learning.
REQ-036 QRS detection: after REQ-035, drive 0,1000,0.
- qrs_pulse is high one cycle after the third sample.
- peak_value=1000, SPKI=475, rr_valid=0.
REQ-037 Noise peak: after REQ-035, drive 0,50,0.
- No pulse.
- NPKI=93, threshold=93+((400-93)>>>2)=169.
REQ-038 Refractory and RR: drive two 1000 peaks whose deciding samples are 3 valid samples apart; the second is ignored. Then drive peaks 10 apart.
- The second peak of the 10-apart pair gives rr_valid=1 and rr_interval=10.
REQ-039 Negative input and reset: drive sample_in=-500 (clamped to 0) with gaps in sample_valid; all state holds during the gaps. Assert reset mid-DETECT.
- All outputs return to 0 asynchronously and learning=1.
- A fresh 8-sample learning phase is required.
